clock_controller: RTL and testbench

Sequences the CPU clock-enable for the subleleks board. It replaces gated/muxed clocks with a single-domain enable pulse. The controller:
- debounces the front-panel MODE and STEP buttons,
- cycles through four speed modes,
- prescales the system clock for the SLOW/FAST modes,
- honours a CPU halt request.
It sits between the board I/O and the CPU core; every CPU register advances only on iCLK edges where oCLK_EN=1.

---
 rtl/clock_controller_pkg.sv | 20 ++
 rtl/clock_controller_if.sv | 33 +++
 rtl/clock_controller_debounce.sv | 49 ++++
 rtl/clock_controller.sv | 99 +++++++++
 tb/tb_clock_controller.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_controller_pkg.sv
// Shared definitions for the CPU clock-enable controller.
//   LIMIT_W   : width of the prescaler limit input
//   mode_e    : speed mode encoding (MANUAL, SLOW, FAST, MAX)
//   next_mode : mode sequence used by the MODE button (wraps MAX -> MANUAL)
package clock_controller_pkg;

  localparam int LIMIT_W = 8;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_SLOW   = 2'd1,
    MODE_FAST   = 2'd2,
    MODE_MAX    = 2'd3
  } mode_e;

  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/clock_controller_if.sv
// Board/CPU-facing signal bundle of the clock controller.
//   iMODE_BTN, iSTEP_BTN : raw asynchronous front-panel buttons (active-high)
//   iLIMIT               : prescaler limit, sampled every cycle
//   iHALT                : CPU halt request (synchronous level)
//   oCLK_EN              : one-cycle CPU clock-enable
//   oMODE                : current speed mode
//   oHALTED              : registered copy of iHALT
//   oCYCLE_COUNT         : number of enable pulses issued (wrapping)
// master = board/CPU side, slave = controller side.
interface clock_controller_if
  import clock_controller_pkg::*;
#(
  parameter int COUNT_W = 16
);
  logic               iMODE_BTN;
  logic               iSTEP_BTN;
  logic [LIMIT_W-1:0] iLIMIT;
  logic               iHALT;
  logic               oCLK_EN;
  mode_e              oMODE;
  logic               oHALTED;
  logic [COUNT_W-1:0] oCYCLE_COUNT;

  modport master (
    output iMODE_BTN, iSTEP_BTN, iLIMIT, iHALT,
    input  oCLK_EN, oMODE, oHALTED, oCYCLE_COUNT
  );

  modport slave (
    input  iMODE_BTN, iSTEP_BTN, iLIMIT, iHALT,
    output oCLK_EN, oMODE, oHALTED, oCYCLE_COUNT
  );
endinterface

// File: rtl/clock_controller_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter and press pulse.
//   clk, rst_n : system clock, asynchronous active-low reset
//   btn        : raw asynchronous button level
//   press      : one-cycle pulse on the accepted 0->1 transition
// The debounced level changes only after the synchronized input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      level_q <= level;
      press   <= level & ~level_q;
      // Any agreeing cycle restarts the stability count.
      if (sync_p1 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/clock_controller.sv
// CPU clock-enable sequencer: single clock domain, produces a one-cycle
// enable instead of a gated clock.
//   iCLK, iRST_N : system clock, asynchronous active-low reset
//   bus          : board/CPU signal bundle (slave side)
// Modes: MANUAL (one enable per STEP press), SLOW/FAST (prescaled periodic
// enable), MAX (enable every cycle). A halted CPU only gets STEP pulses.
module clock_controller
  import clock_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SLOW_SHIFT      = 16,
  parameter int COUNT_W         = 16
) (
  input logic               iCLK,
  input logic               iRST_N,
  clock_controller_if.slave bus
);
  localparam int PW = LIMIT_W + SLOW_SHIFT;

  logic               mode_press;
  logic               step_press;
  mode_e              mode;
  logic [PW-1:0]      presc;
  logic [PW-1:0]      lim;
  logic [PW:0]        slow_span;
  logic               clk_en;
  logic               halted;
  logic [COUNT_W-1:0] cycle_count;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .btn   (bus.iMODE_BTN),
    .press (mode_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .btn   (bus.iSTEP_BTN),
    .press (step_press)
  );

  // SLOW period is (iLIMIT+1) << SLOW_SHIFT, one bit wider than the prescaler
  // before the -1 brings the terminal count back into range.
  assign slow_span = (PW + 1)'({1'b0, bus.iLIMIT} + (LIMIT_W + 1)'(1)) << SLOW_SHIFT;
  assign lim = (mode == MODE_SLOW) ? PW'(slow_span - (PW + 1)'(1)) : PW'(bus.iLIMIT);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      mode        <= MODE_MANUAL;
      presc       <= '0;
      clk_en      <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= '0;
    end else begin
      halted      <= bus.iHALT;
      cycle_count <= cycle_count + COUNT_W'(clk_en);
      if (mode_press) begin
        // Mode change wins over a coincident STEP and restarts the period.
        mode   <= next_mode(mode);
        presc  <= '0;
        clk_en <= 1'b0;
      end else if (bus.iHALT || halted) begin
        // Gating on the incoming halt suppresses a pulse due as oHALTED rises;
        // gating on the registered halt holds the prescaler at 0 on the
        // release edge so a full period follows.
        presc  <= '0;
        clk_en <= step_press;
      end else begin
        unique case (mode)
          MODE_MANUAL: begin
            presc  <= '0;
            clk_en <= step_press;
          end
          MODE_MAX: begin
            presc  <= '0;
            clk_en <= 1'b1;
          end
          default: begin
            // >= keeps a lowered limit from letting the counter run away.
            if (presc >= lim) begin
              presc  <= '0;
              clk_en <= 1'b1;
            end else begin
              presc  <= presc + PW'(1);
              clk_en <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign bus.oCLK_EN      = clk_en;
  assign bus.oMODE        = mode;
  assign bus.oHALTED      = halted;
  assign bus.oCYCLE_COUNT = cycle_count;
endmodule

// File: tb/tb_clock_controller.sv
// Self-checking bench for clock_controller with a behavioural reference model.
module tb_clock_controller;
  localparam int D  = 4;
  localparam int SS = 2;
  localparam int CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  clock_controller_if #(.COUNT_W(CW)) bus ();

  clock_controller #(.DEBOUNCE_CYCLES(D), .SLOW_SHIFT(SS), .COUNT_W(CW)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          cyc = 0;
  bit          m_r1[2], m_r2[2], m_lvl[2];
  int          m_run[2];
  int          m_evq_mode[$];
  int          m_evq_step[$];
  int          m_mode;
  int          m_restart;
  bit          m_en, m_halted;
  logic [CW-1:0] m_cnt;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_r1[b] = 0; m_r2[b] = 0; m_lvl[b] = 0; m_run[b] = 0;
    end
    m_evq_mode.delete();
    m_evq_step.delete();
    m_mode = 0; m_restart = cyc; m_en = 0; m_halted = 0; m_cnt = '0;
  endtask

  task automatic model_step();
    bit raw[2];
    bit ev_mode, ev_step, en;
    int lim;
    raw[0] = bus.iMODE_BTN;
    raw[1] = bus.iSTEP_BTN;
    cyc++;
    ev_mode = (m_evq_mode.size() > 0) && (m_evq_mode[0] == cyc);
    if (ev_mode) void'(m_evq_mode.pop_front());
    ev_step = (m_evq_step.size() > 0) && (m_evq_step[0] == cyc);
    if (ev_step) void'(m_evq_step.pop_front());
    // Button seen two samples late; D disagreeing samples flip the level,
    // a rising flip is consumed by the controller two edges later.
    for (int b = 0; b < 2; b++) begin
      if (m_r2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          m_lvl[b] = m_r2[b];
          m_run[b] = 0;
          if (m_lvl[b]) begin
            if (b == 0) m_evq_mode.push_back(cyc + 2);
            else        m_evq_step.push_back(cyc + 2);
          end
        end
      end else begin
        m_run[b] = 0;
      end
      m_r2[b] = m_r1[b];
      m_r1[b] = raw[b];
    end
    en = 0;
    if (ev_mode) begin
      m_mode = (m_mode + 1) % 4;
      m_restart = cyc;
    end else if (bus.iHALT || m_halted) begin
      m_restart = cyc;
      en = ev_step;
    end else if (m_mode == 0) begin
      m_restart = cyc;
      en = ev_step;
    end else if (m_mode == 3) begin
      m_restart = cyc;
      en = 1;
    end else begin
      lim = (m_mode == 2) ? int'(bus.iLIMIT) : (int'(bus.iLIMIT) + 1) * (1 << SS) - 1;
      if (cyc - m_restart - 1 >= lim) begin
        en = 1;
        m_restart = cyc;
      end
    end
    if (m_en) m_cnt = m_cnt + 1'b1;
    m_en = en;
    m_halted = bus.iHALT;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- stimulus helpers ----------------
  int          n_chk  = 0;
  int          n_pass = 0;
  int          pulse_log[$];
  logic [1:0]  last_mode = 2'd0;
  int          last_mode_edge = 0;

  task automatic tick();
    @(negedge clk);
    if (bus.oCLK_EN === 1'b1) pulse_log.push_back(cyc);
    if (bus.oMODE !== last_mode) begin
      last_mode = bus.oMODE;
      last_mode_edge = cyc;
    end
  endtask

  task automatic press(input bit on_mode, input bit on_step);
    bus.iMODE_BTN = on_mode;
    bus.iSTEP_BTN = on_step;
    for (int i = 0; i < 18; i++) begin
      if (i == 6) begin
        bus.iMODE_BTN = 1'b0;
        bus.iSTEP_BTN = 1'b0;
      end
      tick();
    end
  endtask

  function automatic int count_after(input int t);
    int n = 0;
    foreach (pulse_log[i]) if (pulse_log[i] > t) n++;
    return n;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.iMODE_BTN = 0; bus.iSTEP_BTN = 0; bus.iLIMIT = '0; bus.iHALT = 0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_chk++; if (bus.oCLK_EN !== 1'b0) $display("FAIL reset_clk_en got=%0b exp=0", bus.oCLK_EN); else n_pass++;
    n_chk++; if (bus.oMODE !== 2'd0) $display("FAIL reset_mode got=%0d exp=0", bus.oMODE); else n_pass++;
    n_chk++; if (bus.oHALTED !== 1'b0) $display("FAIL reset_halted got=%0b exp=0", bus.oHALTED); else n_pass++;
    n_chk++; if (bus.oCYCLE_COUNT !== '0) $display("FAIL reset_count got=%0d exp=0", bus.oCYCLE_COUNT); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_manual_step();
    int k, first;
    pulse_log.delete();
    k = cyc + 1;
    bus.iSTEP_BTN = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 10) bus.iSTEP_BTN = 1'b0;
      tick();
      n_chk++; if (bus.oCLK_EN !== m_en) $display("FAIL manual_en cyc=%0d got=%0b exp=%0b", cyc, bus.oCLK_EN, m_en); else n_pass++;
    end
    first = (pulse_log.size() > 0) ? pulse_log[0] : -1;
    n_chk++; if (pulse_log.size() != 1) $display("FAIL manual_pulses got=%0d exp=1", pulse_log.size()); else n_pass++;
    n_chk++; if (first != k + 7) $display("FAIL manual_latency got=%0d exp=%0d", first, k + 7); else n_pass++;
    n_chk++; if (bus.oCYCLE_COUNT !== CW'(1)) $display("FAIL manual_count got=%0d exp=1", bus.oCYCLE_COUNT); else n_pass++;
    // 3-cycle glitch must be rejected
    pulse_log.delete();
    bus.iSTEP_BTN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) bus.iSTEP_BTN = 1'b0;
      tick();
    end
    n_chk++; if (pulse_log.size() != 0) $display("FAIL glitch_pulses got=%0d exp=0", pulse_log.size()); else n_pass++;
  endtask

  task automatic test_mode_cycle();
    int m, n;
    bus.iLIMIT = 8'd3;
    press(1, 0);
    n_chk++; if (bus.oMODE !== 2'd1) $display("FAIL mode_step1 got=%0d exp=1", bus.oMODE); else n_pass++;
    press(1, 0);
    n_chk++; if (bus.oMODE !== 2'd2) $display("FAIL mode_step2 got=%0d exp=2", bus.oMODE); else n_pass++;
    m = last_mode_edge;
    repeat (12) tick();
    n = 0;
    foreach (pulse_log[i]) if (pulse_log[i] > m) begin
      n++;
      n_chk++; if (pulse_log[i] != m + 4 * n) $display("FAIL fast_period got=%0d exp=%0d", pulse_log[i], m + 4 * n); else n_pass++;
    end
    n_chk++; if (n != (cyc - m) / 4) $display("FAIL fast_pulse_count got=%0d exp=%0d", n, (cyc - m) / 4); else n_pass++;
    pulse_log.delete();
    press(1, 0);
    n_chk++; if (bus.oMODE !== 2'd3) $display("FAIL mode_step3 got=%0d exp=3", bus.oMODE); else n_pass++;
    m = last_mode_edge;
    n_chk++; if (count_after(m) != cyc - m) $display("FAIL max_continuous got=%0d exp=%0d", count_after(m), cyc - m); else n_pass++;
    n_chk++; if (count_after(m - 1) != count_after(m)) $display("FAIL max_change_cycle got=1 exp=0"); else n_pass++;
    press(1, 0);
    n_chk++; if (bus.oMODE !== 2'd0) $display("FAIL mode_wrap got=%0d exp=0", bus.oMODE); else n_pass++;
  endtask

  task automatic test_slow_and_limit();
    int m, n;
    logic [1:0] m0;
    bus.iLIMIT = 8'd1;
    pulse_log.delete();
    press(1, 0);
    m = last_mode_edge;
    while (cyc < m + 30) tick();
    n = 0;
    foreach (pulse_log[i]) if (pulse_log[i] > m) begin
      n++;
      n_chk++; if (pulse_log[i] != m + 8 * n) $display("FAIL slow_period got=%0d exp=%0d", pulse_log[i], m + 8 * n); else n_pass++;
    end
    n_chk++; if (n != 3) $display("FAIL slow_pulse_count got=%0d exp=3", n); else n_pass++;
    // enter FAST with limit 5, then drop the limit while the prescaler is at 4
    bus.iLIMIT = 8'd5;
    m0 = bus.oMODE;
    bus.iMODE_BTN = 1'b1;
    for (int i = 0; i < 20 && bus.oMODE === m0; i++) tick();
    bus.iMODE_BTN = 1'b0;
    n_chk++; if (bus.oMODE !== 2'd2) $display("FAIL limit_mode got=%0d exp=2", bus.oMODE); else n_pass++;
    m = cyc;
    repeat (4) tick();
    bus.iLIMIT = 8'd0;
    pulse_log.delete();
    repeat (6) tick();
    n_chk++; if (pulse_log.size() == 0 || pulse_log[0] != m + 5)
      $display("FAIL limit_drop_first got=%0d exp=%0d", (pulse_log.size() > 0) ? pulse_log[0] : -1, m + 5); else n_pass++;
    n_chk++; if (pulse_log.size() != 6) $display("FAIL limit_drop_every got=%0d exp=6", pulse_log.size()); else n_pass++;
    repeat (12) tick();
  endtask

  task automatic test_halt();
    int h, f;
    bus.iLIMIT = 8'd2;
    repeat (9) tick();
    bus.iHALT = 1'b1;
    h = cyc + 1;
    pulse_log.delete();
    repeat (12) tick();
    n_chk++; if (bus.oHALTED !== 1'b1) $display("FAIL halt_flag got=%0b exp=1", bus.oHALTED); else n_pass++;
    n_chk++; if (count_after(h - 1) != 0) $display("FAIL halt_suppress got=%0d exp=0", count_after(h - 1)); else n_pass++;
    pulse_log.delete();
    press(0, 1);
    n_chk++; if (pulse_log.size() != 1) $display("FAIL halt_step got=%0d exp=1", pulse_log.size()); else n_pass++;
    bus.iHALT = 1'b0;
    f = cyc + 1;
    pulse_log.delete();
    repeat (10) tick();
    n_chk++; if (bus.oHALTED !== 1'b0) $display("FAIL unhalt_flag got=%0b exp=0", bus.oHALTED); else n_pass++;
    n_chk++; if (pulse_log.size() == 0 || pulse_log[0] != f + 3)
      $display("FAIL unhalt_first got=%0d exp=%0d", (pulse_log.size() > 0) ? pulse_log[0] : -1, f + 3); else n_pass++;
    n_chk++; if (pulse_log.size() != 3) $display("FAIL unhalt_count got=%0d exp=3", pulse_log.size()); else n_pass++;
  endtask

  task automatic test_simultaneous();
    bus.iLIMIT = 8'd255;
    press(1, 0);
    press(1, 0);
    n_chk++; if (bus.oMODE !== 2'd0) $display("FAIL simul_setup got=%0d exp=0", bus.oMODE); else n_pass++;
    pulse_log.delete();
    press(1, 1);
    n_chk++; if (bus.oMODE !== 2'd1) $display("FAIL simul_mode got=%0d exp=1", bus.oMODE); else n_pass++;
    n_chk++; if (pulse_log.size() != 0) $display("FAIL simul_no_step got=%0d exp=0", pulse_log.size()); else n_pass++;
  endtask

  task automatic test_random();
    int hold_m, hold_s;
    hold_m = 0; hold_s = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold_m == 0) begin bus.iMODE_BTN = $urandom_range(0, 3) == 0; hold_m = $urandom_range(1, 12); end
      else hold_m--;
      if (hold_s == 0) begin bus.iSTEP_BTN = $urandom_range(0, 1); hold_s = $urandom_range(1, 12); end
      else hold_s--;
      if ($urandom_range(0, 15) == 0) bus.iLIMIT = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) bus.iHALT = ~bus.iHALT;
      tick();
      n_chk++; if (bus.oCLK_EN !== m_en) $display("FAIL rnd_en cyc=%0d got=%0b exp=%0b", cyc, bus.oCLK_EN, m_en); else n_pass++;
      n_chk++; if (bus.oMODE !== 2'(m_mode)) $display("FAIL rnd_mode cyc=%0d got=%0d exp=%0d", cyc, bus.oMODE, m_mode); else n_pass++;
      n_chk++; if (bus.oHALTED !== m_halted) $display("FAIL rnd_halted cyc=%0d got=%0b exp=%0b", cyc, bus.oHALTED, m_halted); else n_pass++;
      n_chk++; if (bus.oCYCLE_COUNT !== m_cnt) $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, bus.oCYCLE_COUNT, m_cnt); else n_pass++;
    end
    bus.iMODE_BTN = 0; bus.iSTEP_BTN = 0; bus.iHALT = 0;
    repeat (20) tick();
  endtask

  task automatic test_wrap_reset();
    int m, target;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    bus.iLIMIT = 8'd255;
    press(1, 0); press(1, 0); press(1, 0);
    n_chk++; if (bus.oMODE !== 2'd3) $display("FAIL wrap_mode got=%0d exp=3", bus.oMODE); else n_pass++;
    m = last_mode_edge;
    target = m + 1 + 65539;
    pulse_log.delete();
    while (cyc < target) begin
      tick();
      if (pulse_log.size() > 8) pulse_log.delete();
    end
    n_chk++; if (bus.oCYCLE_COUNT !== CW'(3)) $display("FAIL wrap_count got=%0d exp=3", bus.oCYCLE_COUNT); else n_pass++;
    n_chk++; if (bus.oCYCLE_COUNT !== m_cnt) $display("FAIL wrap_model got=%0d exp=%0d", bus.oCYCLE_COUNT, m_cnt); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.oCLK_EN !== 1'b0) $display("FAIL async_clk_en got=%0b exp=0", bus.oCLK_EN); else n_pass++;
    n_chk++; if (bus.oMODE !== 2'd0) $display("FAIL async_mode got=%0d exp=0", bus.oMODE); else n_pass++;
    n_chk++; if (bus.oCYCLE_COUNT !== '0) $display("FAIL async_count got=%0d exp=0", bus.oCYCLE_COUNT); else n_pass++;
    n_chk++; if (bus.oHALTED !== 1'b0) $display("FAIL async_halted got=%0b exp=0", bus.oHALTED); else n_pass++;
    tick();
    rst_n = 1'b1;
    pulse_log.delete();
    repeat (12) tick();
    n_chk++; if (pulse_log.size() != 0) $display("FAIL post_reset_pulse got=%0d exp=0", pulse_log.size()); else n_pass++;
    n_chk++; if (bus.oCYCLE_COUNT !== '0) $display("FAIL post_reset_count got=%0d exp=0", bus.oCYCLE_COUNT); else n_pass++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_manual_step();
    test_mode_cycle();
    test_slow_and_limit();
    test_halt();
    test_simultaneous();
    test_random();
    test_wrap_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
